instr_sequencer: RTL and testbench
==================================

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- DW, 4, register-file data width.
- AW, 3, register address width (8 registers).
- PCW, 4, program-counter width (16 instructions).
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all state updates on posedge.
- rst_n, in, 1, asynchronous active-low reset.
- start, in, 1, run request; sampled only in IDLE or HALTED.
- instr, in, 12, instruction word from combinational instruction ROM at address pc.
- pc, out, PCW, instruction address.
- a1, out, AW, register-file read address, port 1.
- a2, out, AW, register-file read address, port 2.
- d1, in, DW, register-file read data, port 1 (combinational from a1).
- d2, in, DW, register-file read data, port 2 (combinational from a2).
- a3, out, AW, register-file write address.
- d3, out, DW, register-file write data.
- we3, out, 1, register-file write enable.
- flag_z, out, 1, zero flag.
- flag_c, out, 1, carry/borrow flag.
- busy, out, 1, high in FETCH/EXEC/WB.
- done, out, 1, high while in HALTED.

Function
REQ-003 Instruction format: op=instr[11:9], rd=instr[8:6], rs1=instr[5:3], rs2=instr[2:0], imm=instr[3:0].
REQ-004 Opcodes: 000 NOP, 001 ADD, 010 SUB, 011 AND, 100 OR, 101 XOR, 110 LDI (rd<=imm), 111 HALT.
REQ-005 FSM states IDLE, FETCH, EXEC, WB, HALTED; transitions:
- IDLE/HALTED + start -> FETCH with pc<=0.
- FETCH -> EXEC; IR<=instr.
- EXEC: NOP -> FETCH with pc+1; HALT -> HALTED; otherwise -> WB.
- WB -> FETCH with pc+1.
REQ-006 In EXEC: a1=IR.rs1, a2=IR.rs2; result register <= ALU(d1,d2) or imm (LDI).
REQ-007 In WB, we3=1, a3=IR.rd, d3=result register, for exactly one cycle; we3=0 in every other state.
REQ-008 ADD: {C,R}=d1+d2 as DW+1 bits. SUB: R=d1-d2 mod 2^DW, C=1 iff d1<d2. AND/OR/XOR: C<=0.
REQ-009 Z<=(R==0) in EXEC for ADD/SUB/AND/OR/XOR; LDI, NOP and HALT leave both flags unchanged.
REQ-010 Latency: ALU/LDI instruction 3 cycles; NOP 2 cycles; HALT reaches HALTED 2 cycles after its FETCH.
REQ-011 pc wraps 15 -> 0 without error; execution continues.
REQ-012 start is ignored while busy=1.
REQ-013 a1/a2 hold their last values outside EXEC; a3/d3 are don't-care when we3=0.

Reset
REQ-014 rst_n low asynchronously forces: state IDLE, pc=0, IR=0, result=0, flags=0, we3=0, busy=0, done=0, a1=a2=a3=0.
REQ-015 Reset asserted during WB suppresses the write immediately; no partial or late write occurs.
REQ-016 Release of rst_n is synchronized externally; the block makes no transitions before the first posedge after release.

Structure
REQ-017 Package proc_pkg holds the opcode enum, the FSM state enum, and the DW/AW/PCW/IW constants.
REQ-018 One combinational sub-module, alu: inputs op, a, b; outputs r, c.
REQ-019 The sequencer contains only the FSM, pc, IR, result and flag registers.

Verification
REQ-020 Program LDI r1,5; LDI r2,3; ADD r3,r1,r2; HALT -> r3=8, Z=0, C=0, done rises 11 cycles after start sampled.
REQ-021 LDI r1,3; LDI r2,5; SUB r4,r1,r2 -> r4=14 (0xE), C=1, Z=0.
REQ-022 LDI r1,9; LDI r2,7; ADD r5,r1,r2 -> r5=0, C=1, Z=1; then XOR r6,r1,r1 -> r6=0, Z=1, C=0.
REQ-023 ROM of 16 NOPs, no HALT -> pc wraps 15->0, we3 never asserted, busy stays 1.
REQ-024 rst_n pulsed low during WB of ADD r7 -> r7 unchanged, we3=0 at once, state IDLE, pc=0.
REQ-025 start pulsed during EXEC -> ignored, pc unchanged; start in HALTED -> restart at pc=0, done falls next cycle.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared constants, instruction word layout and enums for the instruction sequencer.
package proc_pkg;

    localparam int DW  = 4;
    localparam int AW  = 3;
    localparam int PCW = 4;
    localparam int IW  = 12;

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_ADD  = 3'b001,
        OP_SUB  = 3'b010,
        OP_AND  = 3'b011,
        OP_OR   = 3'b100,
        OP_XOR  = 3'b101,
        OP_LDI  = 3'b110,
        OP_HALT = 3'b111
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_EXEC   = 3'd2,
        ST_WB     = 3'd3,
        ST_HALTED = 3'd4
    } state_e;

    // LDI reuses the low four bits (rs1[0], rs2) as its immediate.
    typedef struct packed {
        op_e        op;
        logic [2:0] rd;
        logic [2:0] rs1;
        logic [2:0] rs2;
    } instr_t;

endpackage

// File: rtl/alu.sv
// Purpose: combinational ALU for ADD/SUB/AND/OR/XOR with carry/borrow out.
// Latency: zero cycles, purely combinational.
// Backpressure: none; result is valid whenever inputs are.
module alu #(
    parameter int DW = proc_pkg::DW
) (
    input  proc_pkg::op_e   op,
    input  logic [DW-1:0]   a,
    input  logic [DW-1:0]   b,
    output logic [DW-1:0]   r,
    output logic            c
);
    import proc_pkg::*;

    always_comb begin
        r = '0;
        c = 1'b0;
        case (op)
            OP_ADD: {c, r} = {1'b0, a} + {1'b0, b};
            OP_SUB: begin
                r = a - b;
                c = (a < b);
            end
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_XOR: r = a ^ b;
            default: begin
                r = '0;
                c = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/instr_sequencer.sv
// Purpose: multi-cycle FETCH/EXEC/WB sequencer driving an external ROM and register file.
// Latency: ALU/LDI 3 cycles, NOP 2 cycles, HALT reaches HALTED 2 cycles after its fetch.
// Backpressure: none; start is only honoured in IDLE or HALTED and ignored while busy.
module instr_sequencer #(
    parameter int DW  = proc_pkg::DW,
    parameter int AW  = proc_pkg::AW,
    parameter int PCW = proc_pkg::PCW
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [proc_pkg::IW-1:0] instr,
    output logic [PCW-1:0]          pc,
    output logic [AW-1:0]           a1,
    output logic [AW-1:0]           a2,
    input  logic [DW-1:0]           d1,
    input  logic [DW-1:0]           d2,
    output logic [AW-1:0]           a3,
    output logic [DW-1:0]           d3,
    output logic                    we3,
    output logic                    flag_z,
    output logic                    flag_c,
    output logic                    busy,
    output logic                    done
);
    import proc_pkg::*;

    state_e         state_q, state_d;
    logic [PCW-1:0] pc_q, pc_d;
    instr_t         ir_q, ir_d;
    logic [DW-1:0]  res_q, res_d;
    logic           z_q, z_d;
    logic           c_q, c_d;

    logic [DW-1:0]  alu_r;
    logic           alu_c;

    alu #(.DW(DW)) u_alu (
        .op (ir_q.op),
        .a  (d1),
        .b  (d2),
        .r  (alu_r),
        .c  (alu_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            res_q   <= '0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            res_q   <= res_d;
            z_q     <= z_d;
            c_q     <= c_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        res_d   = res_q;
        z_d     = z_q;
        c_d     = c_q;
        case (state_q)
            ST_IDLE, ST_HALTED: begin
                if (start) begin
                    state_d = ST_FETCH;
                    pc_d    = '0;
                end
            end
            ST_FETCH: begin
                ir_d    = instr_t'(instr);
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                case (ir_q.op)
                    OP_NOP: begin
                        state_d = ST_FETCH;
                        pc_d    = pc_q + 1'b1;
                    end
                    OP_HALT: state_d = ST_HALTED;
                    OP_LDI: begin
                        res_d   = DW'({ir_q.rs1[0], ir_q.rs2});
                        state_d = ST_WB;
                    end
                    default: begin
                        res_d   = alu_r;
                        c_d     = alu_c;
                        z_d     = (alu_r == '0);
                        state_d = ST_WB;
                    end
                endcase
            end
            ST_WB: begin
                state_d = ST_FETCH;
                pc_d    = pc_q + 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Read/write addresses come straight from IR, which only changes at the
    // FETCH->EXEC edge, so a1/a2 naturally hold their last EXEC values.
    assign pc     = pc_q;
    assign a1     = AW'(ir_q.rs1);
    assign a2     = AW'(ir_q.rs2);
    assign a3     = AW'(ir_q.rd);
    assign d3     = res_q;
    assign we3    = (state_q == ST_WB);
    assign flag_z = z_q;
    assign flag_c = c_q;
    assign busy   = (state_q == ST_FETCH) || (state_q == ST_EXEC) || (state_q == ST_WB);
    assign done   = (state_q == ST_HALTED);

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: directed programs plus random programs against an ISA-level model.
module tb_instr_sequencer;
    import proc_pkg::*;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [IW-1:0] instr;
    logic [PCW-1:0] pc;
    logic [AW-1:0] a1, a2, a3;
    logic [DW-1:0] d1, d2, d3;
    logic          we3, flag_z, flag_c, busy, done;

    logic [IW-1:0] rom     [16];
    logic [DW-1:0] rf      [8];
    logic [DW-1:0] rf_init [8];
    logic          rf_load = 1'b0;

    typedef struct packed {
        logic [2:0] a;
        logic [3:0] d;
    } wr_t;
    wr_t obs_q[$];
    wr_t exp_q[$];

    int total = 0;
    int bad   = 0;
    int m_rf[8];
    int m_z = 0;
    int m_c = 0;
    int m_cyc;

    instr_sequencer dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .instr  (instr),
        .pc     (pc),
        .a1     (a1),
        .a2     (a2),
        .d1     (d1),
        .d2     (d2),
        .a3     (a3),
        .d3     (d3),
        .we3    (we3),
        .flag_z (flag_z),
        .flag_c (flag_c),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    assign instr = rom[pc];
    assign d1    = rf[a1];
    assign d2    = rf[a2];

    always @(posedge clk) begin
        if (rf_load) begin
            for (int i = 0; i < 8; i++) rf[i] <= rf_init[i];
        end else if (we3) begin
            rf[a3] <= d3;
            obs_q.push_back({a3, d3});
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] enc(input int op, input int rd, input int s1, input int s2);
        logic [11:0] w;
        w = {op[2:0], rd[2:0], s1[2:0], s2[2:0]};
        return w;
    endfunction

    function automatic logic [11:0] ldi(input int rd, input int imm);
        logic [11:0] w;
        w = {3'b110, rd[2:0], 2'b00, imm[3:0]};
        return w;
    endfunction

    task automatic clear_rom();
        for (int i = 0; i < 16; i++) rom[i] = 12'h000;
    endtask

    task automatic load_rf();
        rf_load = 1'b1;
        @(posedge clk);
        #1 rf_load = 1'b0;
    endtask

    // Instruction-level execution: each step applies one instruction's effect
    // and adds its documented cycle cost.
    task automatic model_run();
        int p, op, rd, s1, s2, x, y, r, steps;
        logic [11:0] w;
        bit halted;
        wr_t e;
        p = 0; halted = 0; m_cyc = 0; steps = 0;
        exp_q.delete();
        for (int i = 0; i < 8; i++) m_rf[i] = int'(rf[i]);
        while (!halted && steps < 500) begin
            w = rom[p];
            op = int'(w[11:9]); rd = int'(w[8:6]); s1 = int'(w[5:3]); s2 = int'(w[2:0]);
            x = m_rf[s1]; y = m_rf[s2]; r = 0;
            if (op == 0) begin
                m_cyc += 2;
            end else if (op == 7) begin
                m_cyc += 2;
                halted = 1;
            end else begin
                m_cyc += 3;
                if (op == 6) begin
                    r = int'(w[3:0]);
                end else begin
                    case (op)
                        1: begin r = x + y; m_c = (r > 15) ? 1 : 0; end
                        2: begin r = x - y; m_c = (x < y) ? 1 : 0; end
                        3: begin r = x & y; m_c = 0; end
                        4: begin r = x | y; m_c = 0; end
                        default: begin r = x ^ y; m_c = 0; end
                    endcase
                    r = r & 15;
                    m_z = (r == 0) ? 1 : 0;
                end
                m_rf[rd] = r;
                e.a = rd[2:0];
                e.d = r[3:0];
                exp_q.push_back(e);
            end
            p = (p + 1) % 16;
            steps++;
        end
    endtask

    // Called #1 after a posedge with the DUT in IDLE or HALTED.
    task automatic run_prog(input string tag, input int inject);
        int cyc, base, n;
        model_run();
        base = obs_q.size();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check({tag, ":first_pc"}, pc, 0);
        check({tag, ":done_fall"}, done, 0);
        cyc = 0;
        while (cyc < 400) begin
            @(posedge clk);
            #1;
            cyc++;
            if (inject > 0 && cyc == inject) start = 1'b1;
            if (inject > 0 && cyc == inject + 1) begin
                start = 1'b0;
                check({tag, ":start_ignored_pc"}, pc, 1);
                check({tag, ":start_ignored_busy"}, busy, 1);
            end
            if (done) break;
        end
        check({tag, ":cycles"}, cyc, m_cyc);
        check({tag, ":z"}, flag_z, m_z);
        check({tag, ":c"}, flag_c, m_c);
        for (int i = 0; i < 8; i++) check($sformatf("%s:r%0d", tag, i), rf[i], m_rf[i]);
        n = obs_q.size() - base;
        check({tag, ":nwrites"}, n, exp_q.size());
        for (int k = 0; k < n && k < exp_q.size(); k++)
            check($sformatf("%s:wr%0d", tag, k), obs_q[base + k], exp_q[k]);
    endtask

    initial begin
        int base, busy_low, wrapped, found;
        logic [PCW-1:0] prev_pc;
        logic [11:0] w;
        int nh;

        rst_n = 1'b0;
        start = 1'b0;
        clear_rom();
        for (int i = 0; i < 8; i++) rf_init[i] = DW'($urandom_range(0, 15));
        repeat (2) @(posedge clk);
        #1;
        check("rst:pc", pc, 0);
        check("rst:we3", we3, 0);
        check("rst:busy", busy, 0);
        check("rst:done", done, 0);
        check("rst:flags", {flag_z, flag_c}, 0);
        check("rst:addr", {a1, a2, a3}, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1 check("rst:idle_after_release", {busy, done}, 0);
        load_rf();

        // 5+3 with clean flags; halt 11 cycles after start is sampled
        clear_rom();
        rom[0] = ldi(1, 5); rom[1] = ldi(2, 3); rom[2] = enc(1, 3, 1, 2); rom[3] = 12'hE00;
        run_prog("add8", 0);
        check("add8:r3", rf[3], 8);
        check("add8:cyc11", m_cyc, 11);
        check("add8:zc", {flag_z, flag_c}, 2'b00);

        clear_rom();
        rom[0] = ldi(1, 3); rom[1] = ldi(2, 5); rom[2] = enc(2, 4, 1, 2); rom[3] = 12'hE00;
        run_prog("sub", 0);
        check("sub:r4", rf[4], 14);
        check("sub:zc", {flag_z, flag_c}, 2'b01);

        clear_rom();
        rom[0] = ldi(1, 9); rom[1] = ldi(2, 7); rom[2] = enc(1, 5, 1, 2); rom[3] = 12'hE00;
        run_prog("addwrap", 0);
        check("addwrap:r5", rf[5], 0);
        check("addwrap:zc", {flag_z, flag_c}, 2'b11);

        for (int i = 0; i < 8; i++) rf_init[i] = rf[i];
        rf_init[6] = 4'd5;
        load_rf();
        clear_rom();
        rom[0] = enc(5, 6, 1, 1); rom[1] = 12'hE00;
        run_prog("xor", 0);
        check("xor:r6", rf[6], 0);
        check("xor:zc", {flag_z, flag_c}, 2'b10);

        // start pulsed during EXEC of the second instruction
        clear_rom();
        rom[0] = ldi(1, 4); rom[1] = enc(1, 2, 1, 1); rom[2] = enc(4, 3, 2, 1); rom[3] = 12'hE00;
        run_prog("startexec", 4);

        // reset asserted in the middle of the WB cycle of ADD r7
        for (int i = 0; i < 8; i++) rf_init[i] = rf[i];
        rf_init[7] = 4'd10;
        load_rf();
        clear_rom();
        rom[0] = ldi(1, 2); rom[1] = ldi(2, 3); rom[2] = enc(1, 7, 1, 2); rom[3] = 12'hE00;
        base = obs_q.size();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        found = 0;
        for (int k = 0; k < 50; k++) begin
            @(posedge clk);
            #1;
            if (we3 && a3 == 3'd7) begin
                found = 1;
                break;
            end
        end
        check("rstwb:reached_wb", found, 1);
        rst_n = 1'b0;
        #1;
        check("rstwb:we3", we3, 0);
        check("rstwb:pc", pc, 0);
        check("rstwb:idle", {busy, done}, 0);
        @(posedge clk);
        #1;
        check("rstwb:r7", rf[7], 10);
        check("rstwb:nwrites", obs_q.size() - base, 2);
        @(posedge clk);
        #1 rst_n = 1'b1;
        m_z = 0;
        m_c = 0;

        // all-NOP ROM spins forever through the pc wrap
        clear_rom();
        base = obs_q.size();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        busy_low = 0;
        wrapped = 0;
        prev_pc = pc;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (!busy) busy_low++;
            if (prev_pc == 4'd15 && pc == 4'd0) wrapped = 1;
            prev_pc = pc;
        end
        check("nop:busy_low", busy_low, 0);
        check("nop:wrapped", wrapped, 1);
        check("nop:nwrites", obs_q.size() - base, 0);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        m_z = 0;
        m_c = 0;

        for (int it = 0; it < 25; it++) begin
            for (int i = 0; i < 8; i++) rf_init[i] = DW'($urandom_range(0, 15));
            load_rf();
            nh = $urandom_range(1, 15);
            for (int i = 0; i < 16; i++) begin
                w = 12'($urandom);
                w[11:9] = 3'($urandom_range(0, 6));
                rom[i] = (i == nh) ? 12'hE00 : w;
            end
            run_prog($sformatf("rnd%0d", it), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
